// File: rtl/throttle_ramp_ctrl.sv
// throttle_ramp_ctrl
// Owns the divider-tap select feeding the slow-clock mux. Pushbutton steps and
// host writes are merged into a target level. The applied select walks toward
// that target one level at a time. Each step lands on a slow_clk_in falling
// edge and is followed by a fixed dwell, so the mux only ever switches while
// the slow clock is low. A watchdog bounds the wait for a falling edge in case
// the slow clock has stopped.
module throttle_ramp_ctrl #(
  parameter int MAX_LEVEL   = 5,
  parameter int DWELL_TICKS = 2,
  parameter int WDOG_W      = 27
) (
  input  logic       CLK_50,
  input  logic       reset,
  input  logic       pb_up,
  input  logic       pb_dn,
  input  logic       host_req,
  input  logic [2:0] host_level,
  output logic       host_ack,
  input  logic       slow_clk_in,
  output logic [2:0] freq_sel,
  output logic [2:0] target,
  output logic       tick,
  output logic       busy,
  output logic       wdog_err
);

  localparam logic [2:0] MAX_LVL = 3'(MAX_LEVEL);

  // Dwell counter is just wide enough to hold DWELL_TICKS.
  localparam int DW_W = (DWELL_TICKS < 2) ? 1 : $clog2(DWELL_TICKS + 1);
  localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL_TICKS);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_EDGE = 2'd1;
  localparam logic [1:0] STEP      = 2'd2;
  localparam logic [1:0] DWELL     = 2'd3;

  // Host may ask for any 3-bit value; anything above the fastest tap is pinned.
  function automatic logic [2:0] clamp_level(input logic [2:0] lvl);
    return (lvl > MAX_LVL) ? MAX_LVL : lvl;
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] lvl);
    return (lvl >= MAX_LVL) ? MAX_LVL : lvl + 3'd1;
  endfunction

  function automatic logic [2:0] sat_dec(input logic [2:0] lvl);
    return (lvl == 3'd0) ? 3'd0 : lvl - 3'd1;
  endfunction

  logic              s_d_p0;
  logic              rise;
  logic              fall;
  logic [1:0]        state;
  logic [WDOG_W-1:0] wdog_cnt;
  logic [DW_W-1:0]   dwell_cnt;

  // ---- stage p0: slow clock history, edges decoded against it ----
  assign rise = slow_clk_in & ~s_d_p0;
  assign fall = ~slow_clk_in & s_d_p0;

  assign busy = (state != IDLE);

  // Slow clock history and the rise tick, which runs regardless of FSM state.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      s_d_p0 <= 1'b0;
      tick   <= 1'b0;
    end else begin
      s_d_p0 <= slow_clk_in;
      tick   <= rise;
    end
  end

  // Target arbitration: host write wins, then pushbuttons; simultaneous up+down cancel.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      target   <= 3'd0;
      host_ack <= 1'b0;
    end else if (host_req && !host_ack) begin
      target   <= clamp_level(host_level);
      host_ack <= 1'b1;
    end else begin
      host_ack <= 1'b0;
      if (pb_up && !pb_dn) begin
        target <= sat_inc(target);
      end else if (pb_dn && !pb_up) begin
        target <= sat_dec(target);
      end
    end
  end

  // ---- stage p1: ramp FSM, one level per qualifying falling edge ----
  // Ramp FSM: wait for a fall (or watchdog), move one level, then dwell.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      freq_sel  <= 3'd0;
      wdog_cnt  <= '0;
      dwell_cnt <= '0;
      wdog_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (target != freq_sel) begin
            state    <= WAIT_EDGE;
            wdog_cnt <= '0;
          end
        end
        WAIT_EDGE: begin
          if (target == freq_sel) begin
            // Target moved back onto the applied level before any edge.
            state <= IDLE;
          end else if (fall || (wdog_cnt == '1)) begin
            state <= STEP;
            if (!fall) begin
              wdog_err <= 1'b1;
            end
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end
        STEP: begin
          // Target may have changed since the edge; an equal target means no move,
          // which also keeps freq_sel inside 0..MAX_LEVEL.
          if (target > freq_sel) begin
            freq_sel <= freq_sel + 3'd1;
          end else if (target < freq_sel) begin
            freq_sel <= freq_sel - 3'd1;
          end
          dwell_cnt <= DWELL_LOAD;
          state     <= DWELL;
        end
        DWELL: begin
          if (fall) begin
            if (dwell_cnt <= DWELL_LAST) begin
              dwell_cnt <= '0;
              state     <= IDLE;
            end else begin
              dwell_cnt <= dwell_cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_throttle_ramp_ctrl.sv
// Bench for throttle_ramp_ctrl: directed stimulus with a scoreboard of expected
// freq_sel steps and host acknowledges, checked by a separate monitor.
module tb_throttle_ramp_ctrl;

  localparam int MAX_LEVEL   = 5;
  localparam int DWELL_TICKS = 2;
  localparam int WDOG_W      = 4;
  localparam int HALF        = 5;

  logic       CLK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       pb_up = 1'b0;
  logic       pb_dn = 1'b0;
  logic       host_req = 1'b0;
  logic [2:0] host_level = 3'd0;
  logic       host_ack;
  logic       slow_clk_in = 1'b0;
  logic [2:0] freq_sel;
  logic [2:0] target;
  logic       tick;
  logic       busy;
  logic       wdog_err;

  throttle_ramp_ctrl #(
    .MAX_LEVEL  (MAX_LEVEL),
    .DWELL_TICKS(DWELL_TICKS),
    .WDOG_W     (WDOG_W)
  ) dut (
    .CLK_50     (CLK_50),
    .reset      (reset),
    .pb_up      (pb_up),
    .pb_dn      (pb_dn),
    .host_req   (host_req),
    .host_level (host_level),
    .host_ack   (host_ack),
    .slow_clk_in(slow_clk_in),
    .freq_sel   (freq_sel),
    .target     (target),
    .tick       (tick),
    .busy       (busy),
    .wdog_err   (wdog_err)
  );

  always #5 CLK_50 = ~CLK_50;

  int cyc = 0;
  always @(posedge CLK_50) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic flag(input string name, input int act);
    n_chk++;
    $display("FAIL %s: got %0d, nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Expected events. cyc < 0 means "2 cycles after the latest fall".
  typedef struct {
    logic [2:0] lvl;
    int         cyc;
    int         falls;
  } exp_t;
  exp_t fs_q[$];
  exp_t ack_q[$];

  // Slow clock generator with edge bookkeeping.
  logic slow_en = 1'b0;
  int   ph = 0;
  int   last_fall_cyc = -100;
  int   last_rise_cyc = -100;
  int   fall_cnt = 0;

  always @(posedge CLK_50) begin
    #1;
    if (slow_en) begin
      if (ph == HALF - 1) begin
        ph = 0;
        slow_clk_in = ~slow_clk_in;
        if (slow_clk_in) last_rise_cyc = cyc;
        else begin
          last_fall_cyc = cyc;
          fall_cnt++;
        end
      end else begin
        ph++;
      end
    end else begin
      ph = 0;
      if (slow_clk_in) begin
        slow_clk_in = 1'b0;
        last_fall_cyc = cyc;
        fall_cnt++;
      end
    end
  end

  // Monitor: checks tick, host_ack and every freq_sel change against the queues.
  logic [2:0] prev_fs = 3'd0;
  int         prev_step_falls = 0;

  always @(negedge CLK_50) begin
    exp_t e;
    if (reset) begin
      prev_fs = freq_sel;
    end else begin
      if (tick || (last_rise_cyc == cyc - 1))
        chk("tick", int'(tick), int'(last_rise_cyc == cyc - 1));
      if (host_ack) begin
        if (ack_q.size() == 0) flag("host_ack_unexpected", int'(target));
        else begin
          e = ack_q.pop_front();
          chk("ack_target", int'(target), int'(e.lvl));
          chk("ack_cycle", cyc, e.cyc);
        end
      end
      if (freq_sel != prev_fs) begin
        if (fs_q.size() == 0) flag("freq_sel_unexpected", int'(freq_sel));
        else begin
          e = fs_q.pop_front();
          chk("freq_sel_step", int'(freq_sel), int'(e.lvl));
          if (e.cyc < 0) chk("step_latency", cyc - last_fall_cyc, 2);
          else chk("step_cycle", cyc, e.cyc);
          if (e.falls > 0) chk("dwell_falls", fall_cnt - prev_step_falls, e.falls);
        end
        prev_step_falls = fall_cnt;
        prev_fs = freq_sel;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK_50);
      #2;
    end
  endtask

  task automatic pulse(input logic up, input logic dn);
    pb_up = up;
    pb_dn = dn;
    step();
    pb_up = 1'b0;
    pb_dn = 1'b0;
  endtask

  task automatic host_write(input logic [2:0] lvl, input logic dn, input logic [2:0] exp_tgt);
    exp_t e;
    e.lvl = exp_tgt;
    e.cyc = cyc + 1;
    e.falls = 0;
    ack_q.push_back(e);
    host_req = 1'b1;
    host_level = lvl;
    pb_dn = dn;
    step();
    pb_dn = 1'b0;
    step();
    host_req = 1'b0;
  endtask

  task automatic push_fs(input logic [2:0] lvl, input int c, input int falls);
    exp_t e;
    e.lvl = lvl;
    e.cyc = c;
    e.falls = falls;
    fs_q.push_back(e);
  endtask

  task automatic wait_fs(input logic [2:0] lvl, input int budget);
    int n = 0;
    while (freq_sel != lvl && n < budget) begin
      step();
      n++;
    end
    chk("wait_freq_sel", int'(freq_sel), int'(lvl));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(freq_sel == target && !busy) && n < budget) begin
      step();
      n++;
    end
    chk("settle_in_budget", int'(n < budget), 1);
  endtask

  task automatic wait_falls(input int k);
    int s = fall_cnt;
    int n = 0;
    while (fall_cnt < s + k && n < 200) begin
      step();
      n++;
    end
    chk("fall_in_budget", int'(n < 200), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state
    step(3);
    chk("rst_freq_sel", int'(freq_sel), 0);
    chk("rst_target", int'(target), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_host_ack", int'(host_ack), 0);
    chk("rst_wdog_err", int'(wdog_err), 0);
    reset = 1'b0;
    step();

    // 1) single pb_up, slow clock running
    slow_en = 1'b1;
    push_fs(3'd1, -1, 0);
    pulse(1'b1, 1'b0);
    chk("t1_target", int'(target), 1);
    wait_fs(3'd1, 60);
    wait_falls(1);
    step(2);
    chk("t1_busy_dwell", int'(busy), 1);
    wait_falls(1);
    step(2);
    chk("t1_busy_clear", int'(busy), 0);

    // 2) host write of 7 clamps to 5, ramp 2..5
    push_fs(3'd2, -1, 0);
    push_fs(3'd3, -1, DWELL_TICKS + 1);
    push_fs(3'd4, -1, DWELL_TICKS + 1);
    push_fs(3'd5, -1, DWELL_TICKS + 1);
    host_write(3'd7, 1'b0, 3'd5);
    chk("t2_target", int'(target), 5);
    wait_idle(600);
    chk("t2_freq_sel", int'(freq_sel), 5);

    // 3) collisions and saturation
    pulse(1'b1, 1'b1);
    chk("t3_both_pb", int'(target), 5);
    pulse(1'b1, 1'b0);
    chk("t3_sat_up", int'(target), 5);
    push_fs(3'd4, -1, 0);
    push_fs(3'd3, -1, DWELL_TICKS + 1);
    push_fs(3'd2, -1, DWELL_TICKS + 1);
    host_write(3'd2, 1'b1, 3'd2);
    chk("t3_host_beats_pb", int'(target), 2);
    wait_idle(600);
    push_fs(3'd1, -1, 0);
    push_fs(3'd0, -1, DWELL_TICKS + 1);
    host_write(3'd0, 1'b0, 3'd0);
    wait_idle(600);
    pulse(1'b0, 1'b1);
    chk("t3_sat_dn", int'(target), 0);
    chk("t3_freq_sel", int'(freq_sel), 0);

    // 4) cancel before any fall
    wait_falls(1);
    pb_up = 1'b1;
    step();
    pb_up = 1'b0;
    pb_dn = 1'b1;
    step();
    pb_dn = 1'b0;
    chk("t4_busy_wait", int'(busy), 1);
    chk("t4_target", int'(target), 0);
    step();
    chk("t4_back_idle", int'(busy), 0);
    wait_falls(3);
    chk("t4_freq_sel", int'(freq_sel), 0);

    // 5) stopped slow clock: watchdog forces the step
    slow_en = 1'b0;
    step(3);
    chk("t5_wdog_before", int'(wdog_err), 0);
    push_fs(3'd1, cyc + 19, 0);
    pulse(1'b1, 1'b0);
    wait_fs(3'd1, 40);
    chk("t5_wdog_set", int'(wdog_err), 1);
    slow_en = 1'b1;
    wait_idle(200);
    chk("t5_wdog_sticky", int'(wdog_err), 1);

    // 6) reset during dwell at freq_sel=3
    push_fs(3'd2, -1, 0);
    push_fs(3'd3, -1, DWELL_TICKS + 1);
    host_write(3'd3, 1'b0, 3'd3);
    wait_fs(3'd3, 200);
    step();
    chk("t6_busy_dwell", int'(busy), 1);
    slow_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_freq_sel", int'(freq_sel), 0);
    chk("t6_target", int'(target), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_host_ack", int'(host_ack), 0);
    chk("t6_tick", int'(tick), 0);
    chk("t6_wdog_err", int'(wdog_err), 0);
    step(2);
    reset = 1'b0;
    step(10);
    chk("t6_post_freq_sel", int'(freq_sel), 0);
    chk("t6_post_target", int'(target), 0);
    chk("t6_post_busy", int'(busy), 0);
    chk("t6_post_wdog_err", int'(wdog_err), 0);

    chk("fs_queue_drained", fs_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
